// File: rtl/cdda_stream_if.sv
// Bus bundle for the CD-DA audio stream buffer: sector-side write strobe,
// sample-rate read strobe, control and status/audio outputs.
interface cdda_stream_if #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 11
);
    logic                  WRITE;
    logic [DATA_W-1:0]     DIN;
    logic                  READ;
    logic                  FLUSH;
    logic                  CLR_FLAGS;
    logic [8:0]            VOLUME;
    logic                  WRITE_READY;
    logic [DEPTH_LOG2:0]   LEVEL;
    logic                  OVERFLOW;
    logic                  UNDERRUN;
    logic [DATA_W-1:0]     AUDIO_L;
    logic [DATA_W-1:0]     AUDIO_R;

    modport master (
        output WRITE, DIN, READ, FLUSH, CLR_FLAGS, VOLUME,
        input  WRITE_READY, LEVEL, OVERFLOW, UNDERRUN, AUDIO_L, AUDIO_R
    );
    modport slave (
        input  WRITE, DIN, READ, FLUSH, CLR_FLAGS, VOLUME,
        output WRITE_READY, LEVEL, OVERFLOW, UNDERRUN, AUDIO_L, AUDIO_R
    );
endinterface

// File: rtl/cdda_stream.sv
// CD-DA audio frame buffer: pairs PCM words into frames, circular RAM, volume-scaled pop.
// Optional macro CDDA_VOLUME_RAMP_EN enables a gain register that steps toward VOLUME per pop.
module cdda_stream #(
    parameter int DATA_W        = 16,
    parameter int CHANNELS      = 2,
    parameter int DEPTH_LOG2    = 11,
    parameter int SECTOR_FRAMES = 588
) (
    input  logic          CLK,
    input  logic          nRESET,
    cdda_stream_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = 2 * DATA_W;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] RDY_MAX  = (DEPTH_LOG2+1)'(DEPTH - SECTOR_FRAMES);
    localparam logic                LAST_PH  = 1'(CHANNELS - 1);

    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] rd_data_q;

    logic                  write_d_q, read_d_q;
    logic                  phase_q, phase_d;
    logic [DATA_W-1:0]     stage_q, stage_d;
    logic                  wr_req_q, wr_req_d;
    logic [FW-1:0]         wr_data_q, wr_data_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  commit_q, commit_d;
    logic                  ovf_q, ovf_d, udr_q, udr_d;
    logic [DATA_W-1:0]     aud_l_q, aud_l_d, aud_r_q, aud_r_d;
    logic [8:0]            gain;

    logic write_ce, read_ce, do_commit, drop, head_vld, do_pop;

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s, input logic [8:0] g);
        logic signed [DATA_W+9:0] p;
        logic signed [DATA_W+1:0] sh;
        logic signed [DATA_W+1:0] smax, smin;
        smax = $signed({3'b000, {(DATA_W-1){1'b1}}});
        smin = $signed({3'b111, {(DATA_W-1){1'b0}}});
        p    = $signed(s) * $signed({1'b0, g});
        sh   = p[DATA_W+9:8];
        if (sh > smax)      scale = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sh < smin) scale = {1'b1, {(DATA_W-1){1'b0}}};
        else                scale = sh[DATA_W-1:0];
    endfunction

    // Strobes landing in a FLUSH cycle are dropped; the edge registers still track them.
    assign write_ce  = bus.WRITE & ~write_d_q & ~bus.FLUSH;
    assign read_ce   = bus.READ  & ~read_d_q  & ~bus.FLUSH;
    assign do_commit = wr_req_q & ~bus.FLUSH & (level_q != LVL_FULL);
    assign drop      = wr_req_q & ~bus.FLUSH & (level_q == LVL_FULL);
    // Show-ahead valid: a frame committed on the last edge is not yet in rd_data_q.
    assign head_vld  = level_q > {{DEPTH_LOG2{1'b0}}, commit_q};
    assign do_pop    = read_ce & head_vld;

`ifdef CDDA_VOLUME_RAMP_EN
    logic [8:0] gain_q, gain_d;
    always_comb begin
        gain_d = gain_q;
        if (read_ce && gain_q < bus.VOLUME)      gain_d = gain_q + 9'd1;
        else if (read_ce && gain_q > bus.VOLUME) gain_d = gain_q - 9'd1;
    end
    always_ff @(posedge CLK) begin
        if (!nRESET) gain_q <= '0;
        else         gain_q <= gain_d;
    end
    assign gain = gain_q;
`else
    assign gain = bus.VOLUME;
`endif

    always_comb begin
        phase_d   = phase_q;
        stage_d   = stage_q;
        wr_req_d  = 1'b0;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        commit_d  = do_commit;
        ovf_d     = ovf_q;
        udr_d     = udr_q;
        aud_l_d   = aud_l_q;
        aud_r_d   = aud_r_q;

        if (write_ce) begin
            if (phase_q == LAST_PH) begin
                phase_d   = 1'b0;
                wr_req_d  = 1'b1;
                wr_data_d = (CHANNELS == 2) ? {bus.DIN, stage_q} : {bus.DIN, bus.DIN};
            end else begin
                phase_d = 1'b1;
                stage_d = bus.DIN;
            end
        end
        if (do_commit) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)    rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_commit, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (do_pop) begin
            aud_l_d = scale(rd_data_q[DATA_W-1:0], gain);
            aud_r_d = scale(rd_data_q[FW-1:DATA_W], gain);
        end else if (read_ce) begin
            aud_l_d = '0;
            aud_r_d = '0;
        end

        // A set event in the same cycle as CLR_FLAGS wins.
        if (!bus.FLUSH) begin
            ovf_d = (ovf_q & ~bus.CLR_FLAGS) | drop;
            udr_d = (udr_q & ~bus.CLR_FLAGS) | (read_ce & ~head_vld);
        end

        if (bus.FLUSH) begin
            phase_d  = 1'b0;
            stage_d  = '0;
            wr_req_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            commit_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            write_d_q <= 1'b0;
            read_d_q  <= 1'b0;
            phase_q   <= 1'b0;
            stage_q   <= '0;
            wr_req_q  <= 1'b0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            commit_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
            aud_l_q   <= '0;
            aud_r_q   <= '0;
        end else begin
            write_d_q <= bus.WRITE;
            read_d_q  <= bus.READ;
            phase_q   <= phase_d;
            stage_q   <= stage_d;
            wr_req_q  <= wr_req_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            commit_q  <= commit_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
            aud_l_q   <= aud_l_d;
            aud_r_q   <= aud_r_d;
        end
    end

    // Frame RAM with a registered read port addressed by the next head pointer.
    always_ff @(posedge CLK) begin
        if (do_commit) mem[wr_ptr_q] <= wr_data_q;
        rd_data_q <= mem[rd_ptr_d];
    end

    assign bus.WRITE_READY = (level_q <= RDY_MAX);
    assign bus.LEVEL       = level_q;
    assign bus.OVERFLOW    = ovf_q;
    assign bus.UNDERRUN    = udr_q;
    assign bus.AUDIO_L     = aud_l_q;
    assign bus.AUDIO_R     = aud_r_q;
endmodule

// File: tb/tb_cdda_stream.sv
// Directed bench for cdda_stream: pairing, readability window, flags, scaling,
// flush, fill/overflow and a 5000-frame wrap stream against a queue model.
module tb_cdda_stream;
    logic CLK = 1'b0;
    logic nRESET = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q [$];

    cdda_stream_if #(.DATA_W(16), .DEPTH_LOG2(11)) bus ();
    cdda_stream #(.DATA_W(16), .CHANNELS(2), .DEPTH_LOG2(11), .SECTOR_FRAMES(588))
        dut (.CLK(CLK), .nRESET(nRESET), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        bus.WRITE = 1'b1; bus.DIN = w; tick();
        bus.WRITE = 1'b0; tick();
    endtask

    task automatic write_frame(input logic [15:0] l, input logic [15:0] r);
        write_word(l);
        write_word(r);
    endtask

    task automatic pulse_read();
        bus.READ = 1'b1; tick();
        bus.READ = 1'b0; tick();
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] l, input logic [15:0] r);
        tick(); tick();
        pulse_read();
        chk({tag, "_L"}, 32'(bus.AUDIO_L), 32'(l));
        chk({tag, "_R"}, 32'(bus.AUDIO_R), 32'(r));
    endtask

    initial begin
        bus.WRITE = 0; bus.DIN = 0; bus.READ = 0; bus.FLUSH = 0; bus.CLR_FLAGS = 0;
`ifdef CDDA_VOLUME_RAMP_EN
        bus.VOLUME = 9'd3;
`else
        bus.VOLUME = 9'd256;
`endif
        tick(); tick();
        nRESET = 1'b1; tick();
        chk("rst_level", 32'(bus.LEVEL), 0);
        chk("rst_wready", 32'(bus.WRITE_READY), 1);
        chk("rst_flags", {30'd0, bus.OVERFLOW, bus.UNDERRUN}, 0);
        chk("rst_audio", {bus.AUDIO_L, bus.AUDIO_R}, 0);

`ifdef CDDA_VOLUME_RAMP_EN
        for (int i = 0; i < 3; i++) write_frame(16'h7FFF, 16'h7FFF);
        pop_chk("ramp0", 16'h0000, 16'h0000);
        pop_chk("ramp1", 16'h007F, 16'h007F);
        pop_chk("ramp2", 16'h00FF, 16'h00FF);
`else
        // Basic stereo pairing and pop
        write_frame(16'h1111, 16'h2222);
        chk("basic_lvl1", 32'(bus.LEVEL), 1);
        pop_chk("basic", 16'h1111, 16'h2222);
        chk("basic_lvl0", 32'(bus.LEVEL), 0);
        chk("basic_flags", {30'd0, bus.OVERFLOW, bus.UNDERRUN}, 0);

        // Empty read, flag clear, clear colliding with a new underrun
        pulse_read();
        chk("empty_audio", {bus.AUDIO_L, bus.AUDIO_R}, 0);
        chk("empty_udr", 32'(bus.UNDERRUN), 1);
        bus.CLR_FLAGS = 1'b1; tick(); bus.CLR_FLAGS = 1'b0; tick();
        chk("clr_udr", 32'(bus.UNDERRUN), 0);
        bus.CLR_FLAGS = 1'b1; bus.READ = 1'b1; tick();
        bus.CLR_FLAGS = 1'b0; bus.READ = 1'b0; tick();
        chk("clr_vs_set", 32'(bus.UNDERRUN), 1);
        bus.CLR_FLAGS = 1'b1; tick(); bus.CLR_FLAGS = 1'b0; tick();

        // Read one cycle after commit is inside the not-yet-readable window
        write_frame(16'h0AAA, 16'h0BBB);
        pulse_read();
        chk("early_audio", {bus.AUDIO_L, bus.AUDIO_R}, 0);
        chk("early_udr", 32'(bus.UNDERRUN), 1);
        chk("early_lvl", 32'(bus.LEVEL), 1);
        pop_chk("late", 16'h0AAA, 16'h0BBB);
        chk("late_lvl", 32'(bus.LEVEL), 0);
        bus.CLR_FLAGS = 1'b1; tick(); bus.CLR_FLAGS = 1'b0; tick();

        // Scaling and saturation
        bus.VOLUME = 9'd128; write_frame(16'hC000, 16'h7000);
        pop_chk("vol128", 16'hE000, 16'h3800);
        bus.VOLUME = 9'd384; write_frame(16'h7000, 16'h8000);
        pop_chk("vol384_sat", 16'h7FFF, 16'h8000);
        bus.VOLUME = 9'd0; write_frame(16'h1234, 16'h8000);
        pop_chk("vol0", 16'h0000, 16'h0000);
        bus.VOLUME = 9'd511; write_frame(16'h4000, 16'hFFFF);
        pop_chk("vol511", 16'h7FC0, 16'hFFFE);
        bus.VOLUME = 9'd256;

        // FLUSH discards a staged half-frame
        write_word(16'h1234);
        bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0; tick();
        write_frame(16'hAAAA, 16'hBBBB);
        pop_chk("flush", 16'hAAAA, 16'hBBBB);
        chk("flush_lvl", 32'(bus.LEVEL), 0);

        // Fill to the WRITE_READY threshold, to full, then overflow
        for (int i = 0; i < 1460; i++) write_frame(16'(i), 16'(~i));
        chk("fill_1460_lvl", 32'(bus.LEVEL), 1460);
        chk("fill_1460_wrdy", 32'(bus.WRITE_READY), 1);
        write_frame(16'h0001, 16'h0002);
        chk("fill_1461_wrdy", 32'(bus.WRITE_READY), 0);
        for (int i = 1461; i < 2048; i++) write_frame(16'(i), 16'(~i));
        chk("full_lvl", 32'(bus.LEVEL), 2048);
        chk("full_ovf0", 32'(bus.OVERFLOW), 0);
        write_frame(16'hDEAD, 16'hBEEF);
        chk("ovf_lvl", 32'(bus.LEVEL), 2048);
        chk("ovf_flag", 32'(bus.OVERFLOW), 1);
        bus.FLUSH = 1'b1; tick(); bus.FLUSH = 1'b0; tick();
        chk("fl_lvl", 32'(bus.LEVEL), 0);
        chk("fl_ovf_held", 32'(bus.OVERFLOW), 1);
        chk("fl_wrdy", 32'(bus.WRITE_READY), 1);
        chk("fl_audio_held", {bus.AUDIO_L, bus.AUDIO_R}, {16'hAAAA, 16'hBBBB});
        bus.CLR_FLAGS = 1'b1; tick(); bus.CLR_FLAGS = 1'b0; tick();
        chk("fl_clr", {30'd0, bus.OVERFLOW, bus.UNDERRUN}, 0);

        // Wrap: 5000 frames, reads interleaved keeping about 200 buffered
        for (int i = 0; i < 200; i++) begin
            write_frame(16'(i * 7 + 3), 16'(i ^ 16'hA5A5));
            exp_q.push_back({16'(i ^ 16'hA5A5), 16'(i * 7 + 3)});
        end
        for (int i = 200; i < 5000; i++) begin
            logic [31:0] e;
            bus.WRITE = 1'b1; bus.DIN = 16'(i * 7 + 3); bus.READ = 1'b1; tick();
            bus.WRITE = 1'b0; bus.READ = 1'b0; tick();
            e = exp_q.pop_front();
            chk("wrap_pop", {bus.AUDIO_R, bus.AUDIO_L}, e);
            bus.WRITE = 1'b1; bus.DIN = 16'(i ^ 16'hA5A5); tick();
            bus.WRITE = 1'b0; tick();
            exp_q.push_back({16'(i ^ 16'hA5A5), 16'(i * 7 + 3)});
            chk("wrap_lvl_range", 32'(bus.LEVEL >= 100 && bus.LEVEL <= 300), 1);
        end
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            pulse_read();
            chk("drain_pop", {bus.AUDIO_R, bus.AUDIO_L}, e);
        end
        chk("wrap_lvl_end", 32'(bus.LEVEL), 0);
        chk("wrap_flags", {30'd0, bus.OVERFLOW, bus.UNDERRUN}, 0);

        // Reset mid-frame drops the staged word
        write_word(16'h5555);
        nRESET = 1'b0; tick(); nRESET = 1'b1; tick();
        chk("mrst_audio", {bus.AUDIO_L, bus.AUDIO_R}, 0);
        chk("mrst_lvl", 32'(bus.LEVEL), 0);
        write_frame(16'h0101, 16'h0202);
        pop_chk("mrst", 16'h0101, 16'h0202);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
